// File: rtl/db_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
//   db_state_t : per-channel FSM state; bit 1 of the encoding is the debounced level.
//   cnt_width  : width of the per-channel tick counter for a given STABLE_TICKS.
package db_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_t;

    // ceil(log2(stable_ticks+1)) bits hold 0..stable_ticks
    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/db_chan.sv
// One debounce channel: 2-flop synchronizer, ZERO/WAIT1/ONE/WAIT0 FSM with tick
// counter, and registered edge pulses.
//   clk, reset_n : clock, async active-low reset
//   sw_i         : raw asynchronous switch input
//   tick_i       : shared sample tick
//   db_o         : debounced level
//   rise_o/fall_o: one-cycle pulse on the first cycle of a new debounced level
module db_chan
    import db_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_i,
    input  logic tick_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic          s;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    assign s = sync_q[1];

    // State, counter, synchronizer and pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            state_q <= ZERO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: an input reversal is tested before the tick, so it wins a tie
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = ZERO;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ONE;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = ONE;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ZERO;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is the MSB of the state encoding (ONE, WAIT0 -> 1)
    assign db_o   = state_q[1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/db_multi.sv
// Multi-channel switch debouncer with one shared sample-tick prescaler.
//   clk, reset_n : clock, async active-low reset
//   sw           : NCH raw switch inputs
//   db           : NCH debounced levels
//   rise, fall   : NCH one-cycle edge pulses on db
//   tick         : shared sample tick, high while the prescaler is all-ones
module db_multi
    import db_pkg::*;
#(
    parameter int unsigned NCH          = 4,
    parameter int unsigned TICK_BITS    = 20,
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           tick
);

    logic [TICK_BITS-1:0] pre_q, pre_d;
    logic                 tick_q;

    assign pre_d = pre_q + TICK_BITS'(1);

    // Free-running prescaler; tick_q mirrors "prescaler is all-ones" as a flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == '1);
        end
    end

    assign tick = tick_q;

    // Independent channels
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        db_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .sw_i   (sw[g]),
            .tick_i (tick_q),
            .db_o   (db[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
    end

endmodule

// File: doc/db_multi.md
DB_MULTI -- requirements
Module: db_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent switch channels, range 1..32.
REQ-002 Parameter TICK_BITS, default 20: prescaler width; the sample tick period is 2^TICK_BITS clk cycles (10.49 ms at 100 MHz).
REQ-003 Parameter STABLE_TICKS, default 3: number of consecutive sample ticks an input must hold a new level before db changes, range 1..15.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-006 sw  input  NCH  raw, asynchronous, bouncing switch inputs, one bit per channel.
REQ-007 db  output  NCH  debounced level per channel.
REQ-008 rise  output  NCH  one-cycle pulse per channel when db goes 0->1.
REQ-009 fall  output  NCH  one-cycle pulse per channel when db goes 1->0.
REQ-010 tick  output  1  the shared sample tick, exported for reuse by other blocks.

Function
REQ-011 Prescaler: TICK_BITS-bit free-running up-counter, wrapping to 0; tick SHALL be high exactly in cycles where the counter equals all-ones.
REQ-012 Each sw bit SHALL pass through a 2-flop synchronizer; s[i] (the second flop) is the only value the channel FSM sees.
REQ-013 Each channel FSM SHALL have the states ZERO, WAIT1, ONE and WAIT0, plus a ceil(log2(STABLE_TICKS+1))-bit tick counter cnt.
REQ-014 ZERO: if s=1 -> WAIT1 with cnt=0; otherwise stay.
REQ-015 WAIT1: s=0 -> ZERO; else on tick: if cnt=STABLE_TICKS-1 -> ONE, else cnt+1.
REQ-016 ONE: if s=0 -> WAIT0 with cnt=0; otherwise stay.
REQ-017 WAIT0: s=1 -> ONE; else on tick: if cnt=STABLE_TICKS-1 -> ZERO, else cnt+1.
REQ-018 Simultaneous input reversal and tick in WAIT1 or WAIT0: the reversal wins; the FSM aborts to ONE or ZERO and cnt is not incremented.
REQ-019 db[i] SHALL be 1 in states ONE and WAIT0 and 0 in states ZERO and WAIT1, decoded from the registered state only.
REQ-020 rise[i] SHALL be a registered pulse, high for exactly the first cycle db[i]=1 after a WAIT1->ONE transition; fall[i] likewise for WAIT0->ZERO.
REQ-021 rise[i] and fall[i] SHALL never be high together, and never two cycles in a row.
REQ-022 Acceptance latency: the new level is accepted on the STABLE_TICKS-th tick after entering WAIT*, i.e. (STABLE_TICKS-1)*2^TICK_BITS+1 to STABLE_TICKS*2^TICK_BITS cycles after entry.
REQ-023 Channels SHALL be fully independent: activity on one channel SHALL not affect any other channel's state, cnt or outputs.
REQ-024 An illegal state encoding SHALL return to ZERO on the next clock.

Reset
REQ-025 While reset_n=0: prescaler=0, synchronizer flops=0, every channel in ZERO with cnt=0, and db, rise, fall and tick all 0.
REQ-026 Assertion mid-operation (including mid-WAIT) SHALL abort immediately without producing a rise or fall pulse.
REQ-027 After deassertion, the first tick SHALL occur in cycle 2^TICK_BITS-1 (counted from 0).

Structure
REQ-028 Package db_pkg SHALL hold the state enum db_state_t {ZERO, WAIT1, ONE, WAIT0} and a function computing cnt width from STABLE_TICKS.
REQ-029 Sub-module db_chan (synchronizer, FSM, cnt, pulse registers) SHALL be instantiated NCH times by a generate loop; the prescaler lives in db_multi only.

Verification (NCH=4, TICK_BITS=3, STABLE_TICKS=3; tick every 8 cycles)
REQ-030 Reset values: hold reset_n=0 for 5 cycles, then release -> db=rise=fall=0 throughout; tick first high in cycle 7, then in cycles 15 and 23.
REQ-031 Clean press: sw[0] 0->1 and held -> db[0]=1 between 19 and 27 cycles after the sw edge, rise[0] high for exactly 1 cycle, db[3:1]=0, fall=0.
REQ-032 Bounce: sw[1] toggles every 5 cycles for 60 cycles, then settles at 0 -> db[1] stays 0, with no rise or fall pulse.
REQ-033 Release race: db[2]=1, drive sw[2]=0 so that s[2] drops, then drive it high again so that s[2] returns to 1 in a cycle where tick=1 -> FSM back to ONE, db[2] stays 1, fall[2] stays 0.
REQ-034 Reset mid-WAIT1: sw[3]=1 for 12 cycles, then pulse reset_n low for 1 cycle -> db[3] stays 0 with no rise; once sw[3] stays 1, db[3] rises on the third subsequent tick.
REQ-035 All channels: press all four channels in the same cycle -> all db bits rise in the same cycle and rise=4'b1111 for exactly 1 cycle.
